ysyx_22050710_lsu: RTL and testbench

//  Load/store unit: the memory-side partner of the execute stage. Takes one load or store
//  per command (address = ALU result), drives a 64-bit valid/ready data bus, and returns
//  raw load data right-aligned to bit 0. The execute stage applies the MemOP sign/zero

---
 rtl/ysyx_22050710_lsu_pkg.sv | 26 ++
 rtl/ysyx_22050710_lsu_align.sv | 40 ++++
 rtl/ysyx_22050710_lsu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_22050710_lsu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared definitions for the load/store unit: MemOP encodings, FSM states
// and the access-size decode.
package ysyx_22050710_lsu_pkg;

  localparam logic [2:0] MOP_B    = 3'b000;
  localparam logic [2:0] MOP_BU   = 3'b001;
  localparam logic [2:0] MOP_H    = 3'b010;
  localparam logic [2:0] MOP_HU   = 3'b011;
  localparam logic [2:0] MOP_W    = 3'b100;
  localparam logic [2:0] MOP_WU   = 3'b101;
  localparam logic [2:0] MOP_D    = 3'b110;
  localparam logic [2:0] MOP_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // size code (MemOP[2:1]) to access width in bytes: 1, 2, 4 or 8
  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    bytes_of = 4'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational byte-lane logic: alignment check, store byte enables and
// data placement, and right-alignment of the load beat.
module ysyx_22050710_lsu_align
  import ysyx_22050710_lsu_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] resp_rdata,
  output logic        misalign,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_shifted,
  output logic [63:0] rdata_ext
);

  logic [3:0]  nbytes;
  logic [3:0]  lane_lo;
  logic [3:0]  lane_hi;
  logic [2:0]  lo_mask;
  logic [5:0]  bit_off;
  logic [63:0] rdata_shifted;

  assign nbytes        = bytes_of(size);
  assign lo_mask       = 3'(nbytes - 4'd1);
  assign misalign      = |(addr_lo & lo_mask);
  assign bit_off       = {addr_lo, 3'b000};
  assign wdata_shifted = wdata << bit_off;
  assign rdata_shifted = resp_rdata >> bit_off;
  assign lane_lo       = {1'b0, addr_lo};
  assign lane_hi       = lane_lo + nbytes;

  // a lane is enabled when it falls inside [addr_lo, addr_lo+nbytes)
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      assign wmask[gi]            = (4'(gi) >= lane_lo) && (4'(gi) < lane_hi);
      assign rdata_ext[gi*8 +: 8] = (4'(gi) < nbytes) ? rdata_shifted[gi*8 +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit: accepts one access per command, runs a valid/ready bus
// transaction with a timeout, and reports completion with a one-cycle pulse.
module ysyx_22050710_lsu
  import ysyx_22050710_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_MemWr,
  input  logic [2:0]  i_MemOP,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_rdata,
  output logic        o_misalign,
  output logic        o_err,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [63:0] o_req_addr,
  output logic        o_req_wen,
  output logic [63:0] o_req_wdata,
  output logic [7:0]  o_req_wmask,
  input  logic        i_resp_valid,
  output logic        o_resp_ready,
  input  logic [63:0] i_resp_rdata,
  input  logic        i_resp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_reg, state_next;
  logic [63:0]   addr_reg, addr_next;
  logic [63:0]   wdata_reg, wdata_next;
  logic [63:0]   rdata_reg, rdata_next;
  logic [1:0]    size_reg, size_next;
  logic          wr_reg, wr_next;
  logic          misalign_reg, misalign_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [2:0]    al_addr;
  logic [1:0]    al_size;
  logic          al_misalign;
  logic [7:0]    al_wmask;
  logic [63:0]   al_wdata;
  logic [63:0]   al_rdata;
  logic          timeout_hit;

  // in IDLE the alignment check must see the incoming command
  assign al_addr = (state_reg == IDLE) ? i_addr[2:0]  : addr_reg[2:0];
  assign al_size = (state_reg == IDLE) ? i_MemOP[2:1] : size_reg;

  ysyx_22050710_lsu_align u_align (
    .addr_lo       (al_addr),
    .size          (al_size),
    .wdata         (wdata_reg),
    .resp_rdata    (i_resp_rdata),
    .misalign      (al_misalign),
    .wmask         (al_wmask),
    .wdata_shifted (al_wdata),
    .rdata_ext     (al_rdata)
  );

  // >= covers a request handshake on the last budgeted cycle
  assign timeout_hit = (cnt_reg >= CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      size_reg     <= '0;
      wr_reg       <= 1'b0;
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      size_reg     <= size_next;
      wr_reg       <= wr_next;
      misalign_reg <= misalign_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    size_next     = size_reg;
    wr_next       = wr_reg;
    misalign_next = misalign_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          addr_next  = i_addr;
          wdata_next = i_wdata;
          size_next  = i_MemOP[2:1];
          wr_next    = i_MemWr;
          if (i_MemOP == MOP_NONE) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else if (al_misalign) begin
            misalign_next = 1'b1;
            state_next    = DONE;
          end else begin
            cnt_next   = '0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_reg + 1'b1;
        if (i_req_ready) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      RESP: begin
        cnt_next = cnt_reg + 1'b1;
        if (i_resp_valid) begin
          rdata_next = wr_reg ? 64'd0 : al_rdata;
          err_next   = i_resp_err;
          state_next = DONE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        rdata_next    = '0;
        misalign_next = 1'b0;
        err_next      = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy       = (state_reg != IDLE);
  assign o_done       = (state_reg == DONE);
  assign o_rdata      = rdata_reg;
  assign o_misalign   = misalign_reg;
  assign o_err        = err_reg;
  assign o_req_valid  = (state_reg == REQ);
  assign o_req_addr   = o_req_valid ? {addr_reg[63:3], 3'b000} : 64'd0;
  assign o_req_wen    = o_req_valid & wr_reg;
  assign o_req_wdata  = o_req_wen ? al_wdata : 64'd0;
  assign o_req_wmask  = o_req_wen ? al_wmask : 8'd0;
  assign o_resp_ready = (state_reg == RESP);

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Scoreboard bench for the load/store unit: commands push expected results,
// independent monitors compare bus requests and completions.
module tb_ysyx_22050710_lsu;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_MemWr = 1'b0;
  logic [2:0]  i_MemOP = 3'd0;
  logic [63:0] i_addr = 64'd0;
  logic [63:0] i_wdata = 64'd0;
  logic        i_req_ready = 1'b0;
  logic        i_resp_valid = 1'b0;
  logic [63:0] i_resp_rdata = 64'd0;
  logic        i_resp_err = 1'b0;
  logic        o_busy, o_done, o_misalign, o_err, o_req_valid, o_req_wen, o_resp_ready;
  logic [63:0] o_rdata, o_req_addr, o_req_wdata;
  logic [7:0]  o_req_wmask;

  always #5 clk = ~clk;

  ysyx_22050710_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_MemWr(i_MemWr),
    .i_MemOP(i_MemOP), .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy),
    .o_done(o_done), .o_rdata(o_rdata), .o_misalign(o_misalign), .o_err(o_err),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .o_req_wen(o_req_wen), .o_req_wdata(o_req_wdata), .o_req_wmask(o_req_wmask),
    .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready),
    .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        misalign;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", nm, act, req);
    end
  endtask

  // reference: bytes [off, off+nb) of the beat, right-aligned, rest zero
  function automatic logic [63:0] ref_extract(input logic [63:0] beat, input int off, input int nb);
    logic [63:0] v;
    v = beat >> (8 * off);
    if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
    return v;
  endfunction

  initial begin : done_mon
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (i_rst_n && o_done) begin
        if (exp_q.size() == 0) check("done_unexpected", o_done, 0);
        else begin
          e = exp_q.pop_front();
          check("rdata", o_rdata, e.rdata);
          check("misalign", o_misalign, e.misalign);
          check("err", o_err, e.err);
        end
      end
    end
  end

  initial begin : req_mon
    req_t r;
    forever begin
      @(negedge clk); #1;
      if (i_rst_n && o_req_valid) begin
        if (req_q.size() == 0) check("req_unexpected", o_req_valid, 0);
        else begin
          r = req_q[0];
          check("req_addr", o_req_addr, r.addr);
          check("req_wen", o_req_wen, r.wen);
          check("req_wmask", o_req_wmask, r.wmask);
          if (r.wen) check("req_wdata", o_req_wdata, r.wdata);
          if (i_req_ready) req_q.delete(0);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (o_busy && k < 20) begin @(negedge clk); k++; end
    check({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic drive_resp(input logic [63:0] beat, input logic rerr);
    i_resp_valid = 1'b1;
    i_resp_rdata = beat;
    i_resp_err   = rerr;
  endtask

  // mode 0: normal bus, 1: ready never given, 2: response never given
  task automatic do_cmd(input string tag, input logic wr, input logic [2:0] mop,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] beat, input logic rerr,
                        input int rdly, input int vdly, input int mode);
    exp_t e;
    req_t r;
    int   nb, off, k;
    logic goes;
    nb   = 1 << (int'(mop) / 2);
    off  = int'(addr % 8);
    goes = (mop != 3'd7) && (addr % nb == 0);
    e.misalign = (mop != 3'd7) && !goes;
    e.err      = (mop == 3'd7) || (goes && (mode != 0 || rerr));
    e.rdata    = (goes && mode == 0 && !wr) ? ref_extract(beat, off, nb) : 64'd0;
    exp_q.push_back(e);
    if (goes) begin
      r.addr  = addr - (addr % 8);
      r.wen   = wr;
      r.wmask = wr ? 8'(((1 << nb) - 1) << off) : 8'd0;
      r.wdata = wr ? (wdata << (8 * off)) : 64'd0;
      req_q.push_back(r);
    end
    wait_idle(tag);
    $display("[TB] %s wr=%0d mop=%0d addr=0x%016h wdata=0x%016h beat=0x%016h rerr=%0d rdly=%0d vdly=%0d mode=%0d",
             tag, wr, mop, addr, wdata, beat, rerr, rdly, vdly, mode);
    i_valid = 1'b1; i_MemWr = wr; i_MemOP = mop; i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    i_valid = 1'b0; i_MemWr = $urandom_range(0, 1); i_MemOP = 3'($urandom);
    i_addr = {$urandom, $urandom}; i_wdata = {$urandom, $urandom};
    if (!goes) begin
      check({tag, "_no_req"}, o_req_valid, 0);
      check({tag, "_early_done"}, o_done, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, o_done, 0);
      return;
    end
    if (mode == 0) begin
      repeat (rdly) @(negedge clk);
      i_req_ready = 1'b1;
      if (vdly == 0) drive_resp(beat, rerr);
      @(negedge clk);
      i_req_ready = 1'b0;
      if (vdly > 0) begin
        repeat (vdly) @(negedge clk);
        drive_resp(beat, rerr);
      end
      @(negedge clk);
      i_resp_valid = 1'b0; i_resp_err = 1'b0;
      check({tag, "_done_time"}, o_done, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, o_done, 0);
    end else begin
      if (mode == 2) i_req_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 4 * TIMEOUT && !o_done; c++) begin
        k++;
        @(negedge clk);
        i_req_ready = 1'b0;
      end
      check({tag, "_timeout_cycles"}, 64'(k), 64'(TIMEOUT));
      if (mode == 1 && req_q.size() > 0) req_q.delete(0);
      drive_resp({$urandom, $urandom}, 1'b0);
      @(negedge clk);
      check({tag, "_late_resp_ready"}, o_resp_ready, 0);
      check({tag, "_late_done"}, o_done, 0);
      @(negedge clk);
      check({tag, "_late_busy"}, o_busy, 0);
      i_resp_valid = 1'b0;
    end
  endtask

  task automatic reset_mid_resp();
    req_t r;
    r.addr = 64'h8000_0010; r.wen = 1'b0; r.wmask = 8'd0; r.wdata = 64'd0;
    req_q.push_back(r);
    wait_idle("rst");
    $display("[TB] rst ld addr=0x8000_0010 reset asserted in RESP");
    i_valid = 1'b1; i_MemWr = 1'b0; i_MemOP = 3'b110; i_addr = 64'h8000_0010;
    @(negedge clk);
    i_valid = 1'b0; i_req_ready = 1'b1;
    @(negedge clk);
    i_req_ready = 1'b0;
    check("rst_in_resp", o_resp_ready, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_resp_ready", o_resp_ready, 0);
    check("rst_done", o_done, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_err", o_err, 0);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [2:0]  mop;
    logic [63:0] addr;
    int          nb;
    #1;
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_req_valid", o_req_valid, 0);
    check("reset_resp_ready", o_resp_ready, 0);
    check("reset_rdata", o_rdata, 0);
    check("reset_flags", {o_err, o_misalign}, 0);
    check("reset_req_bus", {o_req_addr, o_req_wmask}, 0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);

    do_cmd("ld",    1'b0, 3'b110, 64'h8000_0008, 64'd0, 64'h1122334455667788, 1'b0, 0, 0, 0);
    do_cmd("lbu",   1'b0, 3'b001, 64'h8000_0005, 64'd0, 64'h1122334455667788, 1'b0, 0, 1, 0);
    do_cmd("lh",    1'b0, 3'b010, 64'h8000_0006, 64'd0, 64'h1122334455667788, 1'b0, 1, 0, 0);
    do_cmd("sw",    1'b1, 3'b100, 64'h8000_0004, 64'hDEADBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 0, 0);
    do_cmd("lw_mis",1'b0, 3'b100, 64'h8000_0002, 64'd0, 64'd0, 1'b0, 0, 0, 0);
    do_cmd("ill",   1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 1'b0, 0, 0, 0);
    do_cmd("to_rsp",1'b0, 3'b110, 64'h8000_0018, 64'd0, 64'd0, 1'b0, 0, 0, 2);
    do_cmd("to_req",1'b1, 3'b100, 64'h8000_0020, 64'h1234, 64'd0, 1'b0, 0, 0, 1);
    do_cmd("berr",  1'b0, 3'b110, 64'h8000_0028, 64'd0, 64'hCAFEF00D_0BADBEEF, 1'b1, 1, 1, 0);
    reset_mid_resp();
    do_cmd("ld2",   1'b0, 3'b110, 64'h8000_0030, 64'd0, 64'h0102030405060708, 1'b0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      mop  = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      nb   = 1 << (int'(mop) / 2);
      addr = 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 6) addr = addr - (addr % nb);
      do_cmd("rnd", 1'($urandom_range(0, 1)), mop, addr, {$urandom, $urandom},
             {$urandom, $urandom}, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
             $urandom_range(0, 2), 0);
    end

    wait_idle("end");
    repeat (2) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 0);
    check("req_q_drained", 64'(req_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
